// File: rtl/mem_port_arbiter.sv
// Byte-serial memory port shared by instruction fetch, load and store.
// Accepts one request at a time: store > load > fetch.
// Reads run one byte per cycle against a memory with one cycle of read latency.
// Writes also run one byte per cycle.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_size,
   input  logic        ld_signed,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [2:0]  st_size,
   input  logic [31:0] st_data,
   input  logic        flush,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [31:0] rdata,
   output logic        if_done,
   output logic        ld_done,
   output logic        st_done
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;
   typedef enum logic [1:0] {OwnNone, OwnIf, OwnLd, OwnSt} owner_e;

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   // Cycle index within a transaction: 1 in the first cycle after acceptance.
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  nbytes_q, nbytes_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        sgn_q, sgn_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        if_done_q, if_done_d;
   logic        ld_done_q, ld_done_d;
   logic        st_done_q, st_done_d;

   logic        st_ok;
   logic [31:0] rbuf_nx;
   logic [1:0]  rd_idx;

   // Anything other than 1 or 2 bytes is a full word.
   function automatic logic [2:0] norm_size(input logic [2:0] s);
      case (s)
         3'd1:    return 3'd1;
         3'd2:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] fmt_rdata(input logic [31:0] w, input logic [2:0] n,
                                             input logic sgn);
      case (n)
         3'd1:    return sgn ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
         3'd2:    return sgn ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      nbytes_d   = nbytes_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      sgn_d      = sgn_q;
      rbuf_d     = rbuf_q;
      rdata_d    = rdata_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      if_done_d  = 1'b0;
      ld_done_d  = 1'b0;
      st_done_d  = 1'b0;
      // I/O-mapped stores wait while the UART buffer is full.
      st_ok      = st_req && !((st_addr[17:16] == 2'b11) && io_buffer_full);
      rd_idx     = 2'(cnt_q - 3'd2);
      rbuf_nx    = rbuf_q;

      unique case (state_q)
         StIdle: begin
            mem_a_d    = 32'd0;
            mem_dout_d = 8'd0;
            mem_wr_d   = 1'b0;
            cnt_d      = 3'd0;
            if (st_ok) begin
               state_d    = StWrite;
               owner_d    = OwnSt;
               addr_d     = st_addr;
               nbytes_d   = norm_size(st_size);
               wdata_d    = st_data;
               sgn_d      = 1'b0;
               cnt_d      = 3'd1;
               mem_a_d    = st_addr;
               mem_dout_d = st_data[7:0];
               mem_wr_d   = 1'b1;
            end else if (!flush && ld_req) begin
               state_d  = StRead;
               owner_d  = OwnLd;
               addr_d   = ld_addr;
               nbytes_d = norm_size(ld_size);
               sgn_d    = ld_signed;
               rbuf_d   = 32'd0;
               cnt_d    = 3'd1;
               mem_a_d  = ld_addr;
            end else if (!flush && if_req) begin
               state_d  = StRead;
               owner_d  = OwnIf;
               addr_d   = if_addr;
               nbytes_d = 3'd4;
               sgn_d    = 1'b0;
               rbuf_d   = 32'd0;
               cnt_d    = 3'd1;
               mem_a_d  = if_addr;
            end
         end

         StRead: begin
            if (flush) begin
               state_d = StIdle;
               owner_d = OwnNone;
               cnt_d   = 3'd0;
               mem_a_d = 32'd0;
            end else begin
               // Data for the address of cycle k arrives in cycle k+1.
               if (cnt_q >= 3'd2) begin
                  case (rd_idx)
                     2'd0:    rbuf_nx[7:0]   = mem_din;
                     2'd1:    rbuf_nx[15:8]  = mem_din;
                     2'd2:    rbuf_nx[23:16] = mem_din;
                     default: rbuf_nx[31:24] = mem_din;
                  endcase
                  rbuf_d = rbuf_nx;
               end
               if (cnt_q == nbytes_q + 3'd1) begin
                  state_d = StIdle;
                  owner_d = OwnNone;
                  cnt_d   = 3'd0;
                  mem_a_d = 32'd0;
                  rdata_d = fmt_rdata(rbuf_nx, nbytes_q, sgn_q);
                  unique case (owner_q)
                     OwnIf:   if_done_d = 1'b1;
                     OwnLd:   ld_done_d = 1'b1;
                     default: ;
                  endcase
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  mem_a_d = (cnt_q < nbytes_q) ? addr_q + {29'd0, cnt_q} : 32'd0;
               end
            end
         end

         StWrite: begin
            // Stores are committed: flush is ignored here.
            if (cnt_q == nbytes_q) begin
               state_d    = StIdle;
               owner_d    = OwnNone;
               cnt_d      = 3'd0;
               mem_a_d    = 32'd0;
               mem_dout_d = 8'd0;
               mem_wr_d   = 1'b0;
               st_done_d  = (owner_q == OwnSt);
            end else begin
               cnt_d      = cnt_q + 3'd1;
               mem_a_d    = addr_q + {29'd0, cnt_q};
               mem_dout_d = byte_sel(wdata_q, cnt_q[1:0]);
               mem_wr_d   = 1'b1;
            end
         end

         default: begin
            state_d    = StIdle;
            owner_d    = OwnNone;
            cnt_d      = 3'd0;
            mem_a_d    = 32'd0;
            mem_dout_d = 8'd0;
            mem_wr_d   = 1'b0;
         end
      endcase
   end

   // State register; reset wins over rdy, rdy low freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         owner_q    <= OwnNone;
         cnt_q      <= 3'd0;
         nbytes_q   <= 3'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         sgn_q      <= 1'b0;
         rbuf_q     <= 32'd0;
         rdata_q    <= 32'd0;
         mem_a_q    <= 32'd0;
         mem_dout_q <= 8'd0;
         mem_wr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         ld_done_q  <= 1'b0;
         st_done_q  <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         nbytes_q   <= nbytes_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         sgn_q      <= sgn_d;
         rbuf_q     <= rbuf_d;
         rdata_q    <= rdata_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         if_done_q  <= if_done_d;
         ld_done_q  <= ld_done_d;
         st_done_q  <= st_done_d;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q;
   assign rdata    = rdata_q;
   assign if_done  = if_done_q;
   assign ld_done  = ld_done_q;
   assign st_done  = st_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for priority, flush, I/O gating, reset and stall.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst, rdy;
   logic        if_req, ld_req, st_req, ld_signed, flush, io_buffer_full;
   logic [31:0] if_addr, ld_addr, st_addr, st_data;
   logic [2:0]  ld_size, st_size;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a, rdata;
   logic        mem_wr, if_done, ld_done, st_done;
   logic [2:0]  done_vec;

   int n_checks = 0;
   int n_errors = 0;

   // Byte memory with one cycle of read latency, stalled by rdy.
   logic [7:0]  mem [0:4095];
   logic        pre_we;
   logic [31:0] pre_addr, pre_word;

   mem_port_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .ld_req         (ld_req),
      .ld_addr        (ld_addr),
      .ld_size        (ld_size),
      .ld_signed      (ld_signed),
      .st_req         (st_req),
      .st_addr        (st_addr),
      .st_size        (st_size),
      .st_data        (st_data),
      .flush          (flush),
      .io_buffer_full (io_buffer_full),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .rdata          (rdata),
      .if_done        (if_done),
      .ld_done        (ld_done),
      .st_done        (st_done)
   );

   assign done_vec = {st_done, ld_done, if_done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) begin
         for (int i = 0; i < 4; i++) mem[12'(pre_addr + 32'(i))] <= pre_word[8*i +: 8];
      end else if (rdy) begin
         mem_din <= mem[mem_a[11:0]];
         if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
      end
   end

   typedef struct {
      int          kind;       // 0 fetch, 1 load, 2 store
      logic [31:0] addr;
      logic [2:0]  size;
      logic        sgn;
      logic [31:0] data;
      logic [31:0] init;
      int          n;
      int          exp_k;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      pre_addr = a;
      pre_word = w;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // Waits (bounded) for any done pulse; checks latency, owner and rdata.
   task automatic await_done(input string nm, input logic [2:0] exp_vec, input int exp_k,
                             input bit chk_rd, input logic [31:0] exp_rd);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done_vec == 3'b000 && k < 20);
      chk({nm, " latency"}, 32'(k), 32'(exp_k));
      chk({nm, " owner"}, {29'd0, done_vec}, {29'd0, exp_vec});
      if (chk_rd) chk({nm, " rdata"}, rdata, exp_rd);
   endtask

   task automatic quiet_window(input string nm, input int cycles);
      logic [2:0] seen;
      seen = 3'b000;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         seen = seen | done_vec;
      end
      chk(nm, {29'd0, seen}, 32'd0);
   endtask

   task automatic run_vec(input int idx);
      vec_t        v;
      logic [31:0] tmp;
      logic [2:0]  ev;
      string       nm;
      v  = vecs[idx];
      nm = $sformatf("vec%0d", idx);
      preload(v.addr, (v.kind == 2) ? 32'd0 : v.init);
      ev = 3'b001 << v.kind;
      case (v.kind)
         0: begin if_addr = v.addr; if_req = 1'b1; end
         1: begin ld_addr = v.addr; ld_size = v.size; ld_signed = v.sgn; ld_req = 1'b1; end
         default: begin st_addr = v.addr; st_size = v.size; st_data = v.data; st_req = 1'b1; end
      endcase
      for (int k = 1; k <= v.exp_k; k++) begin
         @(negedge clk);
         if (k <= v.n) begin
            chk($sformatf("%s c%0d mem_a", nm, k), mem_a, v.addr + 32'(k - 1));
            chk($sformatf("%s c%0d mem_wr", nm, k), {31'd0, mem_wr}, {31'd0, v.kind == 2});
            if (v.kind == 2) begin
               tmp = v.data >> (8 * (k - 1));
               chk($sformatf("%s c%0d mem_dout", nm, k), {24'd0, mem_dout}, {24'd0, tmp[7:0]});
            end
         end
         if (k == v.exp_k) begin
            chk({nm, " done"}, {29'd0, done_vec}, {29'd0, ev});
            if (v.kind != 2) chk({nm, " rdata"}, rdata, v.exp_rdata);
            chk({nm, " idle mem_wr"}, {31'd0, mem_wr}, 32'd0);
            chk({nm, " idle mem_a"}, mem_a, 32'd0);
         end else begin
            chk($sformatf("%s c%0d no done", nm, k), {29'd0, done_vec}, 32'd0);
         end
      end
      if_req = 1'b0;
      ld_req = 1'b0;
      st_req = 1'b0;
      if (v.kind == 2) begin
         for (int i = 0; i < 4; i++) begin
            tmp = (i < v.n) ? (v.data >> (8 * i)) : 32'd0;
            chk($sformatf("%s mem byte %0d", nm, i), {24'd0, mem[12'(v.addr + 32'(i))]},
                {24'd0, tmp[7:0]});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //          kind addr          size sgn data          init          n  k  rdata
      vecs[0]  = '{0, 32'h0000_0100, 3'd4, 1'b0, 32'h0,        32'h0000_0513, 4, 6, 32'h0000_0513};
      vecs[1]  = '{1, 32'h0000_0040, 3'd1, 1'b1, 32'h0,        32'h0000_0080, 1, 3, 32'hFFFF_FF80};
      vecs[2]  = '{1, 32'h0000_0040, 3'd1, 1'b0, 32'h0,        32'h0000_0080, 1, 3, 32'h0000_0080};
      vecs[3]  = '{1, 32'h0000_0050, 3'd2, 1'b1, 32'h0,        32'h5566_8234, 2, 4, 32'hFFFF_8234};
      vecs[4]  = '{1, 32'h0000_0050, 3'd2, 1'b0, 32'h0,        32'h5566_8234, 2, 4, 32'h0000_8234};
      vecs[5]  = '{1, 32'h0000_0060, 3'd3, 1'b1, 32'h0,        32'h8011_2233, 4, 6, 32'h8011_2233};
      vecs[6]  = '{1, 32'h0000_0044, 3'd1, 1'b1, 32'h0,        32'hAAAA_AA7F, 1, 3, 32'h0000_007F};
      vecs[7]  = '{2, 32'h0000_0070, 3'd4, 1'b0, 32'hCAFE_F00D, 32'h0,        4, 5, 32'h0};
      vecs[8]  = '{2, 32'h0000_0080, 3'd1, 1'b0, 32'h1234_5678, 32'h0,        1, 2, 32'h0};
      vecs[9]  = '{2, 32'h0000_0090, 3'd0, 1'b0, 32'h0102_0304, 32'h0,        4, 5, 32'h0};
      vecs[10] = '{0, 32'hFFFF_FFFE, 3'd4, 1'b0, 32'h0,        32'hDEAD_BEEF, 4, 6, 32'hDEAD_BEEF};
      vecs[11] = '{2, 32'h0000_0088, 3'd2, 1'b0, 32'hAABB_CCDD, 32'h0,        2, 3, 32'h0};

      rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; ld_signed = 1'b0;
      if_addr = 32'd0; ld_addr = 32'd0; st_addr = 32'd0; st_data = 32'd0;
      ld_size = 3'd0; st_size = 3'd0; pre_we = 1'b0; pre_addr = 32'd0; pre_word = 32'd0;
      mem_din = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset mem_a", mem_a, 32'd0);
      chk("reset mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("reset mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset done", {29'd0, done_vec}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) run_vec(i);

      // Simultaneous requests: store, then load, then fetch.
      preload(32'h210, 32'h1122_3344);
      preload(32'h220, 32'h5566_7788);
      st_addr = 32'h200; st_size = 3'd2; st_data = 32'h0000_BEEF; st_req = 1'b1;
      ld_addr = 32'h210; ld_size = 3'd4; ld_signed = 1'b0; ld_req = 1'b1;
      if_addr = 32'h220; if_req = 1'b1;
      @(negedge clk);
      chk("prio c1 mem_wr", {31'd0, mem_wr}, 32'd1);
      chk("prio c1 mem_a", mem_a, 32'h200);
      chk("prio c1 mem_dout", {24'd0, mem_dout}, 32'hEF);
      @(negedge clk);
      chk("prio c2 mem_a", mem_a, 32'h201);
      chk("prio c2 mem_dout", {24'd0, mem_dout}, 32'hBE);
      await_done("prio st", 3'b100, 1, 1'b0, 32'd0);
      st_req = 1'b0;
      await_done("prio ld", 3'b010, 6, 1'b1, 32'h1122_3344);
      ld_req = 1'b0;
      await_done("prio if", 3'b001, 6, 1'b1, 32'h5566_7788);
      if_req = 1'b0;

      // Flush in cycle 2 of a fetch aborts it.
      if_addr = 32'h100; if_req = 1'b1;
      @(negedge clk);
      chk("flush c1 mem_a", mem_a, 32'h100);
      @(negedge clk);
      chk("flush c2 mem_a", mem_a, 32'h101);
      flush = 1'b1;
      @(negedge clk);
      chk("flush abort mem_a", mem_a, 32'd0);
      chk("flush abort mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("flush abort done", {29'd0, done_vec}, 32'd0);
      flush = 1'b0; if_req = 1'b0;
      quiet_window("flush no if_done", 6);

      // Flush blocks load acceptance at that edge only.
      ld_addr = 32'h40; ld_size = 3'd1; ld_signed = 1'b0; ld_req = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush blocks load", mem_a, 32'd0);
      flush = 1'b0;
      @(negedge clk);
      chk("load after flush mem_a", mem_a, 32'h40);
      await_done("load after flush", 3'b010, 2, 1'b1, 32'h80);
      ld_req = 1'b0;

      // Flush neither blocks nor aborts a store.
      st_addr = 32'h300; st_size = 3'd4; st_data = 32'h1122_3344; st_req = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush st accepted", {31'd0, mem_wr}, 32'd1);
      chk("flush st c1 mem_a", mem_a, 32'h300);
      @(negedge clk);
      @(negedge clk);
      chk("flush st c3 mem_a", mem_a, 32'h302);
      flush = 1'b0;
      await_done("flush st", 3'b100, 2, 1'b0, 32'd0);
      st_req = 1'b0;
      for (int i = 0; i < 4; i++)
         chk($sformatf("flush st byte %0d", i), {24'd0, mem[12'h300 + 12'(i)]},
             32'h1122_3344 >> (8 * i) & 32'hFF);

      // I/O store held off while the buffer is full; fetch served meanwhile.
      io_buffer_full = 1'b1;
      st_addr = 32'h3_0000; st_size = 3'd1; st_data = 32'h0000_00A5; st_req = 1'b1;
      if_addr = 32'h100; if_req = 1'b1;
      @(negedge clk);
      chk("io c1 mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("io c1 fetch mem_a", mem_a, 32'h100);
      await_done("io fetch", 3'b001, 5, 1'b1, 32'h0000_0513);
      if_req = 1'b0;
      @(negedge clk);
      chk("io held c7", {31'd0, mem_wr}, 32'd0);
      @(negedge clk);
      chk("io held c8", {31'd0, mem_wr}, 32'd0);
      io_buffer_full = 1'b0;
      @(negedge clk);
      chk("io st mem_wr", {31'd0, mem_wr}, 32'd1);
      chk("io st mem_a", mem_a, 32'h3_0000);
      chk("io st mem_dout", {24'd0, mem_dout}, 32'hA5);
      await_done("io st", 3'b100, 1, 1'b0, 32'd0);
      st_req = 1'b0;
      chk("io st mem byte", {24'd0, mem[0]}, 32'hA5);

      // Reset mid-read, with rdy low: everything clears, no done.
      if_addr = 32'h100; if_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; rdy = 1'b0;
      @(negedge clk);
      chk("rst mem_a", mem_a, 32'd0);
      chk("rst mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst done", {29'd0, done_vec}, 32'd0);
      rst = 1'b0; rdy = 1'b1; if_req = 1'b0;
      quiet_window("rst no done", 6);

      // rdy low for 3 cycles mid-read delays completion by 3.
      if_addr = 32'h100; if_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall hold mem_a %0d", i), mem_a, 32'h101);
         chk($sformatf("stall no done %0d", i), {29'd0, done_vec}, 32'd0);
      end
      rdy = 1'b1;
      await_done("stall fetch", 3'b001, 4, 1'b1, 32'h0000_0513);
      if_req = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
